// File: rtl/plugboard_ctrl.sv
// plugboard_ctrl: programmable Steckerbrett pair table and swap stage; define PLUG_UNDO_EN to add an undo port.
module plugboard_ctrl #(
  parameter int MAX_PAIRS = 10
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [25:0] letter_in,
  input  logic        prog,
  input  logic        clear,
`ifdef PLUG_UNDO_EN
  input  logic        undo,
`endif
  output logic [25:0] letter_out,
  output logic [3:0]  pair_count,
  output logic        full,
  output logic        err,
  output logic [1:0]  pstate
);
  localparam int IW = MAX_PAIRS > 1 ? $clog2(MAX_PAIRS) : 1;
  typedef enum logic [1:0] {RUN = 2'd0, FIRST = 2'd1, SECOND = 2'd2, COMMIT = 2'd3} state_t;
  state_t r_state, w_next;
  logic [25:0] r_letter_q, r_letter_out, w_swap;
  logic [4:0]  r_first, r_second, w_idx, w_partner;
  logic [3:0]  r_count;
  logic [IW-1:0] w_free, w_top;
  logic r_err, w_err, w_onehot, w_event, w_hit, w_latch1, w_latch2, w_commit, w_pop, w_undo;
  logic          r_valid [MAX_PAIRS];
  logic [4:0]    r_a     [MAX_PAIRS];
  logic [4:0]    r_b     [MAX_PAIRS];
`ifdef PLUG_UNDO_EN
  logic [IW-1:0] r_stack [MAX_PAIRS];
  assign w_undo = undo;
  assign w_top  = r_stack[IW'(r_count - 4'd1)];
`else
  assign w_undo = 1'b0;
  assign w_top  = IW'(r_count - 4'd1);
`endif
  assign w_onehot   = $onehot(letter_in);
  assign w_event    = w_onehot && letter_in != r_letter_q;
  assign w_swap     = (w_onehot && w_hit) ? 26'd1 << w_partner : letter_in;
  assign full       = r_count == 4'(MAX_PAIRS);
  assign letter_out = r_letter_out;
  assign pair_count = r_count;
  assign err        = r_err;
  assign pstate     = r_state;
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 26; i++) if (letter_in[i]) w_idx = 5'(i);
  end
  // A letter is "hit" if it sits on either side of a valid pair; w_partner is the other side.
  always_comb begin
    w_hit = 1'b0;
    w_partner = '0;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (r_valid[i] && r_a[i] == w_idx) begin
        w_hit = 1'b1;
        w_partner = r_b[i];
      end
      if (r_valid[i] && r_b[i] == w_idx) begin
        w_hit = 1'b1;
        w_partner = r_a[i];
      end
    end
  end
  always_comb begin
    w_free = '0;
    for (int i = MAX_PAIRS - 1; i >= 0; i--) if (!r_valid[i]) w_free = IW'(i);
  end
  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    w_latch1 = 1'b0;
    w_latch2 = 1'b0;
    w_commit = 1'b0;
    w_pop = 1'b0;
    if (clear) w_next = prog ? FIRST : RUN;
    else case (r_state)
      RUN: begin
        w_next = prog ? FIRST : RUN;
        w_pop = w_undo && r_count != 0;
        w_err = w_undo && r_count == 0;
      end
      FIRST: begin
        w_pop = w_undo && r_count != 0;
        w_err = w_undo ? r_count == 0 : prog && w_event && (w_hit || full);
        w_latch1 = prog && !w_undo && w_event && !w_hit && !full;
        w_next = !prog ? RUN : w_latch1 ? SECOND : FIRST;
      end
      SECOND: begin
        w_err = prog && !w_undo && w_event && (w_hit || w_idx == r_first);
        w_latch2 = prog && !w_undo && w_event && !w_hit && w_idx != r_first;
        w_next = !prog ? RUN : w_latch2 ? COMMIT : (w_undo || w_err) ? FIRST : SECOND;
      end
      default: begin
        w_commit = 1'b1;
        w_next = prog ? FIRST : RUN;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= RUN;
      r_letter_q <= '0;
      r_letter_out <= '0;
      r_err <= 1'b0;
      r_count <= '0;
      r_first <= '0;
      r_second <= '0;
      for (int i = 0; i < MAX_PAIRS; i++) r_valid[i] <= 1'b0;
    end else begin
      r_state <= w_next;
      r_letter_q <= letter_in;
      r_err <= w_err;
      r_letter_out <= w_next == RUN ? w_swap : '0;
      if (w_latch1) r_first <= w_idx;
      if (w_latch2) r_second <= w_idx;
      if (clear) begin
        for (int i = 0; i < MAX_PAIRS; i++) r_valid[i] <= 1'b0;
        r_count <= '0;
      end else if (w_commit) begin
        r_valid[w_free] <= 1'b1;
        r_a[w_free] <= r_first;
        r_b[w_free] <= r_second;
        r_count <= r_count + 4'd1;
`ifdef PLUG_UNDO_EN
        r_stack[IW'(r_count)] <= w_free;
`endif
      end else if (w_pop) begin
        r_valid[w_top] <= 1'b0;
        r_count <= r_count - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_plugboard_ctrl.sv
// tb_plugboard_ctrl: randomized keystroke-level bench against a letter-map reference model.
module tb_plugboard_ctrl;
  localparam int MAXP = 10;
  logic clk = 1'b0;
  logic rst;
  logic [25:0] letter_in;
  logic prog, clear;
`ifdef PLUG_UNDO_EN
  logic undo;
`endif
  logic [25:0] letter_out;
  logic [3:0] pair_count;
  logic full, err;
  logic [1:0] pstate;
  int total = 0, bad = 0, errs = 0;
  int pmap[26];
  int order[$];
  int cnt = 0, fst = 0;
  bit pend = 0, pmode = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (err === 1'b1) errs++;
  plugboard_ctrl #(.MAX_PAIRS(MAXP)) dut (
    .CLOCK_50(clk), .reset(rst), .letter_in(letter_in), .prog(prog), .clear(clear),
`ifdef PLUG_UNDO_EN
    .undo(undo),
`endif
    .letter_out(letter_out), .pair_count(pair_count), .full(full), .err(err), .pstate(pstate)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic status(input string tag);
    chk({tag, ":count"}, 32'(pair_count), 32'(cnt));
    chk({tag, ":full"}, 32'(full), 32'(cnt == MAXP));
    chk({tag, ":pstate"}, 32'(pstate), !pmode ? 32'd0 : pend ? 32'd2 : 32'd1);
  endtask
  task automatic model_clear();
    foreach (pmap[i]) pmap[i] = -1;
    order.delete();
    cnt = 0;
    pend = 0;
  endtask
  task automatic key(input int x);
    int e0, e;
    e0 = errs;
    e = 0;
    letter_in = 26'd1 << x;
    tick(2);
    letter_in = '0;
    tick(2);
    if (!pend) begin
      if (pmap[x] >= 0 || cnt == MAXP) e = 1;
      else begin
        pend = 1;
        fst = x;
      end
    end else begin
      if (x == fst || pmap[x] >= 0) e = 1;
      else begin
        pmap[fst] = x;
        pmap[x] = fst;
        cnt++;
        order.push_back(fst);
      end
      pend = 0;
    end
    chk("key:err", 32'(errs - e0), 32'(e));
    status("key");
  endtask
  task automatic prog_on();
    letter_in = '0;
    prog = 1'b1;
    tick(2);
    pmode = 1;
    pend = 0;
    status("prog_on");
  endtask
  task automatic prog_off();
    prog = 1'b0;
    tick(2);
    pmode = 0;
    pend = 0;
    status("prog_off");
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    model_clear();
    status("clear");
  endtask
`ifdef PLUG_UNDO_EN
  task automatic do_undo();
    int e0, e, f;
    e0 = errs;
    e = 0;
    undo = 1'b1;
    tick(1);
    undo = 1'b0;
    tick(1);
    if (pmode && pend) pend = 0;
    else if (cnt == 0) e = 1;
    else begin
      f = order.pop_back();
      pmap[pmap[f]] = -1;
      pmap[f] = -1;
      cnt--;
    end
    chk("undo:err", 32'(errs - e0), 32'(e));
    status("undo");
  endtask
`endif
  task automatic run_chk(input logic [25:0] v);
    logic [25:0] exp;
    int idx;
    letter_in = v;
    tick(1);
    exp = v;
    if ($countones(v) == 1) begin
      idx = 0;
      for (int i = 0; i < 26; i++) if (v[i]) idx = i;
      if (pmap[idx] >= 0) exp = 26'd1 << pmap[idx];
    end
    chk("run:letter_out", 32'(letter_out), 32'(exp));
  endtask
  initial begin
    rst = 1'b1;
    letter_in = '0;
    prog = 1'b0;
    clear = 1'b0;
`ifdef PLUG_UNDO_EN
    undo = 1'b0;
`endif
    model_clear();
    tick(3);
    rst = 1'b0;
    chk("reset:letter_out", 32'(letter_out), 32'd0);
    chk("reset:err", 32'(err), 32'd0);
    status("reset");
    tick(1);
    run_chk(26'h4);
    prog_on();
    key(0);
    key(1);
    prog_off();
    run_chk(26'h1);
    run_chk(26'h2);
    run_chk(26'h4);
    prog_on();
    key(0);
    key(2);
    key(2);
    key(2);
    key(0);
    do_clear();
    for (int i = 0; i < 20; i++) key(i);
    key(20);
    do_clear();
    prog_off();
    run_chk(26'h1);
    prog_on();
    key(3);
    prog_off();
    run_chk(26'h8);
    run_chk(26'h3);
    run_chk(26'h0);
`ifdef PLUG_UNDO_EN
    prog_on();
    key(0);
    key(1);
    key(2);
    key(3);
    do_undo();
    prog_off();
    run_chk(26'h4);
    run_chk(26'h1);
    do_undo();
    do_undo();
    prog_on();
    key(4);
    do_undo();
    prog_off();
`endif
    for (int s = 0; s < 8; s++) begin
      prog_on();
      for (int k = 0; k < 14; k++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) do_clear();
`ifdef PLUG_UNDO_EN
        else if (r == 1) do_undo();
`endif
        else key(int'($urandom_range(0, s < 4 ? 11 : 25)));
      end
      prog_off();
      for (int k = 0; k < 12; k++) begin
        int r;
        logic [25:0] v;
        r = int'($urandom_range(0, 7));
        v = 26'd1 << $urandom_range(0, 25);
        if (r == 0) v = '0;
        else if (r == 1) v = v | (26'd1 << $urandom_range(0, 25));
        run_chk(v);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
